// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Holds the program counter, reads a
//            combinational instruction ROM and fills the IF/ID pipeline
//            register. Supports stall, redirect (redirect beats stall) and
//            an optional misaligned-redirect trap.
// Ports    : clk          - sole clock, rising edge
//            rst_n        - asynchronous active-low reset
//            imem_addr    - ROM word address (pc[11:2])
//            imem_data    - ROM word, same cycle
//            stall        - downstream cannot accept an instruction
//            redirect     - taken branch / jump from execute
//            redirect_pc  - redirect target byte address
//            id_valid     - IF/ID holds a real instruction
//            id_pc        - byte address of id_instr
//            id_instr     - instruction word to decode
//            misalign     - sticky misaligned-redirect flag
// Config   : FETCH_MISALIGN_TRAP_EN - when defined, a redirect to a
//            non-word-aligned target freezes fetch (HALT) and sets
//            misalign; when undefined the low target bits are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [9:0]  imem_addr,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        misalign
);

   localparam logic [31:0] C_NOP = 32'h0000_0013;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic        r_id_valid, w_id_valid_nxt;
   logic [31:0] r_id_pc, w_id_pc_nxt;
   logic [31:0] r_id_instr, w_id_instr_nxt;
   logic        w_misalign_set;
   logic        w_bad_target;
   logic [31:0] w_target;

   // Low two bits of the target are simply forced to zero.
   assign w_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign w_bad_target = (redirect_pc[1:0] != 2'b00);
`else
   assign w_bad_target = 1'b0;
`endif

   assign imem_addr = r_pc[11:2];
   assign id_valid  = r_id_valid;
   assign id_pc     = r_id_pc;
   assign id_instr  = r_id_instr;

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_id_valid_nxt = r_id_valid;
      w_id_pc_nxt    = r_id_pc;
      w_id_instr_nxt = r_id_instr;
      w_misalign_set = 1'b0;
      case (r_state)
         RUN: begin
            if (redirect) begin
               if (w_bad_target) begin
                  // Trap: pc keeps the old value, fetch freezes for good.
                  w_misalign_set = 1'b1;
                  w_id_valid_nxt = 1'b0;
                  w_state_nxt    = HALT;
               end else begin
                  // Squash whatever was in IF/ID; id_pc intentionally held.
                  w_pc_nxt       = w_target;
                  w_id_valid_nxt = 1'b0;
                  w_id_instr_nxt = C_NOP;
               end
            end else if (!stall) begin
               w_pc_nxt       = r_pc + 32'd4;   // wraps modulo 2^32
               w_id_pc_nxt    = r_pc;
               w_id_instr_nxt = imem_data;
               w_id_valid_nxt = 1'b1;
            end
         end
         HALT: begin
            w_id_valid_nxt = 1'b0;
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= RUN;
         r_pc       <= RESET_PC;
         r_id_valid <= 1'b0;
         r_id_pc    <= RESET_PC;
         r_id_instr <= C_NOP;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_id_valid <= w_id_valid_nxt;
         r_id_pc    <= w_id_pc_nxt;
         r_id_instr <= w_id_instr_nxt;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic r_misalign;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_misalign <= 1'b0;
      end else if (w_misalign_set) begin
         r_misalign <= 1'b1;
      end
   end

   assign misalign = r_misalign;
`else
   logic w_unused_set;
   assign w_unused_set = w_misalign_set;
   assign misalign     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: byte address fetched first after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_addr  output  10  word address to the combinational instruction ROM.
REQ-005 SHALL have port imem_data  input  32  instruction word returned by the ROM in the same cycle.
REQ-006 SHALL have port stall  input  1  decode/execute cannot accept a new instruction this cycle.
REQ-007 SHALL have port redirect  input  1  taken branch or jump from execute.
REQ-008 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-009 SHALL have port id_valid  output  1  IF/ID register holds a real instruction.
REQ-010 SHALL have port id_pc  output  32  byte address of id_instr.
REQ-011 SHALL have port id_instr  output  32  fetched instruction to decode.
REQ-012 SHALL have port misalign  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-013 SHALL hold a 32-bit pc register; imem_addr SHALL equal pc[11:2] combinationally.
REQ-014 SHALL implement FSM states RUN and HALT; reset state RUN.
REQ-015 In RUN, no redirect, no stall: pc <= pc+4; id_pc <= pc; id_instr <= imem_data; id_valid <= 1.
REQ-016 In RUN, stall without redirect: pc, id_pc, id_instr, id_valid SHALL all hold.
REQ-017 Redirect SHALL take priority over stall: pc <= {redirect_pc[31:2],2'b00}; id_valid <= 0; id_instr <= 32'h0000_0013 (NOP); id_pc holds.
REQ-018 Redirect-to-new-instruction latency SHALL be exactly 2 edges: target in pc after edge 1, in IF/ID after edge 2 (if not stalled).
REQ-019 pc+4 SHALL wrap modulo 2^32; imem_addr therefore wraps every 4 KiB, no error.
REQ-020 In HALT: pc frozen; id_valid 0; stall and redirect ignored; exit only by reset.
REQ-021 Redirect asserted in the same cycle as stall release SHALL behave as REQ-017 (no instruction from the old path delivered).

Reset
REQ-022 While rst_n=0: pc=RESET_PC, id_valid=0, id_pc=RESET_PC, id_instr=32'h0000_0013, misalign=0, state RUN.
REQ-023 Reset asserted mid-operation SHALL take effect immediately, independent of clk, discarding any pending redirect or stall.
REQ-024 First edge after rst_n release SHALL load the RESET_PC instruction into IF/ID with id_valid=1 (absent stall/redirect).

Configuration
REQ-025 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 SHALL NOT update pc; SHALL set misalign=1 (sticky), clear id_valid, enter HALT on that edge.
REQ-026 Macro undefined: redirect_pc[1:0] SHALL be silently ignored per REQ-017; misalign SHALL be tied 0; HALT unreachable.

Verification
REQ-027 Reset release, ROM word0=0x00000533, word1=0x00250513, no stall -> edge1: id_pc=0, id_instr=0x00000533, id_valid=1; edge2: id_pc=4, id_instr=0x00250513.
REQ-028 stall=1 for 3 cycles at pc=0x08 -> imem_addr stays 2, IF/ID unchanged 3 cycles, then id_pc=0x08 on first unstalled edge.
REQ-029 redirect=1, stall=1, redirect_pc=0x28 -> next edge: pc=0x28, id_valid=0, id_instr=0x00000013; after stall drops, id_pc=0x28, id_instr=ROM word 10.
REQ-030 RESET_PC=0xFFFF_FFFC, run 2 cycles -> id_pc 0xFFFF_FFFC then 0x0000_0000, imem_addr 0x3FF then 0x000.
REQ-031 With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x0000_0022 -> misalign=1, id_valid=0, pc unchanged for 10 cycles; rst_n pulse clears misalign. Without macro, same stimulus -> pc=0x20, misalign=0.
REQ-032 rst_n asserted between edges mid-run -> outputs reach REQ-022 values before next clk edge.
